// File: rtl/spreading_factors_pkg.sv
// +------------------------------------------------------------------+
// | spreading_factors_pkg                                            |
// | Shared DCSK frame size, spreading-factor codes and wrap lookup.  |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

package spreading_factors_pkg;

  localparam int FRAME_BITS = 32;
  localparam int CTR_W      = 10;

  typedef enum logic [1:0] {
    SF2  = 2'd0,
    SF4  = 2'd1,
    SF8  = 2'd2,
    SF16 = 2'd3
  } sf_e;

  // Last counter value of a frame: FRAME_BITS * 2 * 2^(code+1) chips minus one.
  function automatic logic [CTR_W-1:0] sf_wrap(input sf_e sf);
    case (sf)
      SF2:     return 10'd127;
      SF4:     return 10'd255;
      SF8:     return 10'd511;
      default: return 10'd1023;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/dcsk_tx_chip_ctr.sv
// +------------------------------------------------------------------+
// | dcsk_tx_chip_ctr                                                 |
// | Stall-safe frame chip counter with SF wrap flag and decode.      |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

module dcsk_tx_chip_ctr
  import spreading_factors_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_arst_n,
  input  logic       i_en,
  input  logic       i_clr,
  input  logic [1:0] i_sf,
  output logic       o_last,
  output logic [4:0] o_chip_index,
  output logic [4:0] o_bit_index,
  output logic       o_ref_phase
);

  logic [CTR_W-1:0] r_ctr;
  sf_e              w_sf;

  assign w_sf = sf_e'(i_sf);

  // Clear has priority so a finishing or aborted frame never leaves a stale count.
  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      r_ctr <= '0;
    end else if (i_clr) begin
      r_ctr <= '0;
    end else if (i_en) begin
      r_ctr <= r_ctr + 1'b1;
    end
  end

  assign o_last = (r_ctr == sf_wrap(w_sf));

  always_comb begin
    o_chip_index = 5'd0;
    o_bit_index  = 5'd0;
    o_ref_phase  = 1'b1;
    case (w_sf)
      SF2: begin
        o_chip_index = {3'd0, r_ctr[1:0]};
        o_ref_phase  = ~r_ctr[1];
        o_bit_index  = r_ctr[6:2];
      end
      SF4: begin
        o_chip_index = {2'd0, r_ctr[2:0]};
        o_ref_phase  = ~r_ctr[2];
        o_bit_index  = r_ctr[7:3];
      end
      SF8: begin
        o_chip_index = {1'b0, r_ctr[3:0]};
        o_ref_phase  = ~r_ctr[3];
        o_bit_index  = r_ctr[8:4];
      end
      default: begin
        o_chip_index = r_ctr[4:0];
        o_ref_phase  = ~r_ctr[4];
        o_bit_index  = r_ctr[9:5];
      end
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/dcsk_tx_ctrl.sv
// +------------------------------------------------------------------+
// | dcsk_tx_ctrl                                                     |
// | DCSK transmit frame sequencer: frame handshake, chip stepping.   |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

module dcsk_tx_ctrl
  import spreading_factors_pkg::*;
(
  input  logic                  i_clk,
  input  logic                  i_arst_n,
  input  logic [1:0]            i_sf,
  input  logic                  i_frame_valid,
  input  logic [FRAME_BITS-1:0] i_frame_data,
  output logic                  o_frame_ready,
  input  logic                  i_abort,
  output logic                  o_chip_valid,
  input  logic                  i_chip_ready,
  output logic [4:0]            o_chip_index,
  output logic [4:0]            o_bit_index,
  output logic                  o_ref_phase,
  output logic                  o_data_bit,
  output logic                  o_ref_wr,
  output logic                  o_ref_rd,
  output logic                  o_frame_done,
  output logic                  o_busy
);

  localparam logic [1:0] c_st_idle = 2'd0;
  localparam logic [1:0] c_st_run  = 2'd1;
  localparam logic [1:0] c_st_done = 2'd2;

  logic [1:0]            r_state;
  logic [1:0]            w_state_nxt;
  logic [FRAME_BITS-1:0] r_frame_q;
  sf_e                   r_sf_q;
  logic                  w_accept;
  logic                  w_run;
  logic                  w_last;
  logic                  w_ctr_en;
  logic                  w_ctr_clr;

  assign w_accept  = (r_state == c_st_idle) & i_frame_valid;
  assign w_run     = (r_state == c_st_run);
  // Abort beats the final handshake: the counter clears instead of advancing.
  assign w_ctr_en  = w_run & i_chip_ready & ~i_abort;
  assign w_ctr_clr = w_accept | (w_run & (i_abort | (w_last & i_chip_ready)));

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      r_state <= c_st_idle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_st_idle: if (w_accept) w_state_nxt = c_st_run;
      c_st_run: begin
        if (i_abort)                    w_state_nxt = c_st_idle;
        else if (w_last & i_chip_ready) w_state_nxt = c_st_done;
      end
      c_st_done: w_state_nxt = c_st_idle;
      default:   w_state_nxt = c_st_idle;
    endcase
  end

  always_comb begin
    o_frame_ready = 1'b0;
    o_chip_valid  = 1'b0;
    o_frame_done  = 1'b0;
    o_busy        = 1'b1;
    case (r_state)
      c_st_idle: begin
        o_frame_ready = 1'b1;
        o_busy        = 1'b0;
      end
      c_st_run:  o_chip_valid = 1'b1;
      c_st_done: o_frame_done = 1'b1;
      default:   o_busy       = 1'b1;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      r_frame_q <= '0;
      r_sf_q    <= SF2;
    end else if (w_accept) begin
      r_frame_q <= i_frame_data;
      r_sf_q    <= sf_e'(i_sf);
    end
  end

  dcsk_tx_chip_ctr u_chip_ctr (
    .i_clk        (i_clk),
    .i_arst_n     (i_arst_n),
    .i_en         (w_ctr_en),
    .i_clr        (w_ctr_clr),
    .i_sf         (r_sf_q),
    .o_last       (w_last),
    .o_chip_index (o_chip_index),
    .o_bit_index  (o_bit_index),
    .o_ref_phase  (o_ref_phase)
  );

  assign o_data_bit = r_frame_q[o_bit_index];
  assign o_ref_wr   = o_chip_valid & i_chip_ready & o_ref_phase;
  assign o_ref_rd   = o_chip_valid & i_chip_ready & ~o_ref_phase;

endmodule

`default_nettype wire

// File: tb/tb_dcsk_tx_ctrl.sv
// +------------------------------------------------------------------+
// | tb_dcsk_tx_ctrl                                                  |
// | Directed vector bench for the DCSK transmit frame sequencer.     |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

module tb_dcsk_tx_ctrl;

  logic        clk;
  logic        arst_n;
  logic [1:0]  sf;
  logic        frame_valid;
  logic [31:0] frame_data;
  logic        frame_ready;
  logic        abort;
  logic        chip_valid;
  logic        chip_ready;
  logic [4:0]  chip_index;
  logic [4:0]  bit_index;
  logic        ref_phase;
  logic        data_bit;
  logic        ref_wr;
  logic        ref_rd;
  logic        frame_done;
  logic        busy;

  int total = 0;
  int bad   = 0;

  dcsk_tx_ctrl dut (
    .i_clk         (clk),
    .i_arst_n      (arst_n),
    .i_sf          (sf),
    .i_frame_valid (frame_valid),
    .i_frame_data  (frame_data),
    .o_frame_ready (frame_ready),
    .i_abort       (abort),
    .o_chip_valid  (chip_valid),
    .i_chip_ready  (chip_ready),
    .o_chip_index  (chip_index),
    .o_bit_index   (bit_index),
    .o_ref_phase   (ref_phase),
    .o_data_bit    (data_bit),
    .o_ref_wr      (ref_wr),
    .o_ref_rd      (ref_rd),
    .o_frame_done  (frame_done),
    .o_busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  sf;
    logic [31:0] data;
    int          toggle;     // 1: chip_ready alternates 1,0 starting high
    int          sf_change;  // 1: drive i_sf to SF8 after 50 handshakes
    int          exp_hs;
    int          exp_wr;
    int          exp_rd;
    int          exp_done;   // cycle of frame_done counted from acceptance
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // All tasks start and end 1 time unit after a rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_frame(input logic [1:0] s, input logic [31:0] d);
    int w = 0;
    while (!frame_ready && w < 50) begin
      tick();
      w++;
    end
    chk("frame_ready_wait", int'(frame_ready), 1);
    sf          = s;
    frame_data  = d;
    frame_valid = 1'b1;
    tick();
    frame_valid = 1'b0;
  endtask

  task automatic advance(input int n);
    repeat (n) begin
      chip_ready = 1'b1;
      tick();
    end
    chip_ready = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int n = 0, wr = 0, rd = 0, t = 1, done_t = -1, errs = 0;
    int cpb, eci, ebi, eref, edb;
    logic rdy;
    cpb = 4 << v.sf;
    start_frame(v.sf, v.data);
    while (t < 5000 && done_t < 0) begin
      if (frame_done) begin
        done_t = t;
      end else begin
        if (v.sf_change != 0 && n == 50) sf = 2'd2;
        rdy = (v.toggle != 0) ? logic'(t % 2 == 1) : 1'b1;
        chip_ready = rdy;
        #1;
        eci  = n % cpb;
        ebi  = (n / cpb) % 32;
        eref = (eci < cpb / 2) ? 1 : 0;
        edb  = int'(v.data[ebi]);
        if (chip_valid !== 1'b1 || int'(chip_index) != eci || int'(bit_index) != ebi ||
            int'(ref_phase) != eref || int'(data_bit) != edb ||
            ref_wr !== (rdy & eref[0]) || ref_rd !== (rdy & ~eref[0])) begin
          if (errs == 0)
            $display("  %s: first chip error at n=%0d ci=%0d bi=%0d ph=%0d db=%0d", tag, n,
                     chip_index, bit_index, ref_phase, data_bit);
          errs++;
        end
        if (rdy) n++;
        if (ref_wr) wr++;
        if (ref_rd) rd++;
        @(posedge clk);
        #1;
        t++;
      end
    end
    chip_ready = 1'b0;
    chk({tag, "_done_cycle"}, done_t, v.exp_done);
    chk({tag, "_handshakes"}, n, v.exp_hs);
    chk({tag, "_ref_wr"}, wr, v.exp_wr);
    chk({tag, "_ref_rd"}, rd, v.exp_rd);
    chk({tag, "_chip_errs"}, errs, 0);
    chk({tag, "_ready_in_done"}, int'(frame_ready), 0);
    tick();
    chk({tag, "_done_pulse_end"}, int'(frame_done), 0);
    chk({tag, "_ready_after"}, int'(frame_ready), 1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_frame_ready"}, int'(frame_ready), 1);
    chk({tag, "_chip_valid"}, int'(chip_valid), 0);
    chk({tag, "_ref_wr_rd"}, int'({ref_wr, ref_rd}), 0);
    chk({tag, "_done_busy"}, int'({frame_done, busy}), 0);
    chk({tag, "_indices"}, int'({chip_index, bit_index}), 0);
    chk({tag, "_ref_phase"}, int'(ref_phase), 1);
    chk({tag, "_data_bit"}, int'(data_bit), 0);
  endtask

  initial begin
    int done_seen;

    vecs[0] = '{2'd0, 32'hA5A5_A5A5, 0, 0, 128, 64, 64, 129};
    vecs[1] = '{2'd1, 32'h0000_FFFF, 0, 0, 256, 128, 128, 257};
    vecs[2] = '{2'd3, 32'h1234_5678, 1, 0, 1024, 512, 512, 2048};
    vecs[3] = '{2'd0, 32'hDEAD_BEEF, 0, 1, 128, 64, 64, 129};
    vecs[4] = '{2'd2, 32'h8000_0001, 0, 0, 512, 256, 256, 513};

    arst_n      = 1'b0;
    sf          = 2'd0;
    frame_valid = 1'b0;
    frame_data  = 32'h0;
    abort       = 1'b0;
    chip_ready  = 1'b0;
    #12;
    chk_reset_outputs("reset");
    arst_n = 1'b1;
    tick();

    for (int i = 0; i < 5; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Stall on the last chip of an SF4 frame.
    start_frame(2'd1, 32'hF0F0_F0F0);
    advance(255);
    done_seen = 0;
    repeat (5) begin
      if (frame_done || !chip_valid || chip_index != 5'd7 || bit_index != 5'd31) done_seen++;
      tick();
    end
    chk("stall_last_hold", done_seen, 0);
    chip_ready = 1'b1;
    #1;
    chk("stall_last_ref_rd", int'({ref_wr, ref_rd}), 1);
    tick();
    chip_ready = 1'b0;
    chk("stall_last_done", int'(frame_done), 1);
    tick();
    chk("stall_last_ready", int'(frame_ready), 1);

    // Abort mid-frame at ctr=40.
    start_frame(2'd0, 32'h0F0F_0F0F);
    advance(40);
    chk("abort40_ci", int'(chip_index), 0);
    chk("abort40_bi", int'(bit_index), 10);
    abort      = 1'b1;
    chip_ready = 1'b1;
    tick();
    abort      = 1'b0;
    chip_ready = 1'b0;
    chk("abort40_idle", int'({frame_ready, chip_valid, busy}), 3'b100);
    done_seen = 0;
    repeat (3) begin
      if (frame_done) done_seen++;
      tick();
    end
    chk("abort40_no_done", done_seen, 0);
    run_vec(vecs[0], "after_abort40");

    // Abort together with the last handshake.
    start_frame(2'd0, 32'h1357_9BDF);
    advance(127);
    abort      = 1'b1;
    chip_ready = 1'b1;
    tick();
    abort      = 1'b0;
    chip_ready = 1'b0;
    chk("abort_last_idle", int'({frame_ready, frame_done, busy}), 3'b100);
    tick();
    chk("abort_last_no_done", int'(frame_done), 0);

    // Asynchronous reset mid-frame at ctr=300, SF8.
    start_frame(2'd2, 32'hFFFF_FFFF);
    advance(300);
    chk("pre_reset_bi", int'(bit_index), 18);
    chip_ready = 1'b1;
    #2;
    arst_n = 1'b0;
    #1;
    chk_reset_outputs("async_reset");
    #2;
    arst_n     = 1'b1;
    chip_ready = 1'b0;
    tick();
    chk("post_reset_no_done", int'(frame_done), 0);
    run_vec(vecs[1], "after_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
